// File: rtl/ram_march_tester_if.sv
// RAM read-write port bundle between the march tester (master) and the RAM (slave).
// Latency: none, wires only; read_data is expected combinationally in the cycle read_enable is high.
// Backpressure: none, the RAM accepts one operation every cycle.
// Ports: write_enable, read_enable, address, write_data (master to slave); read_data (slave to master).
interface ram_march_tester_if #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic                     write_enable;
  logic                     read_enable;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [WIDTH-1:0]         write_data;
  logic [WIDTH-1:0]         read_data;

  modport master (
    output write_enable, read_enable, address, write_data,
    input  read_data
  );

  modport slave (
    input  write_enable, read_enable, address, write_data,
    output read_data
  );
endinterface

// File: rtl/ram_march_tester.sv
// March C- built-in self-test initiator for a single-port RAM; reports pass/fail and the first failing word.
// Latency: one RAM op per cycle, 10*DEPTH cycles per fault-free run; done rises the cycle after the last op.
// Backpressure: none; start is ignored while busy, abort cancels a run and wins over a simultaneous start.
// Ports: clock, resetn; start/abort in; busy/done/pass and fail_address/fail_expected/fail_actual out;
//        ram (ram_march_tester_if.master) carries write_enable, read_enable, address, write_data, read_data.
module ram_march_tester #(
  parameter int             WIDTH         = 8,
  parameter int             DEPTH         = 16,
  parameter int             ADDRESS_WIDTH = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] BACKGROUND  = '0,
  parameter bit             STOP_ON_FAIL  = 1'b0
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ADDRESS_WIDTH-1:0] fail_address,
  output logic [WIDTH-1:0]         fail_expected,
  output logic [WIDTH-1:0]         fail_actual,
  ram_march_tester_if.master       ram
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [2:0]               ELEM_LAST = 3'd5;

  state_t                   state_q, state_d;
  logic [2:0]               elem_q, elem_d;      // march element M0..M5
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     phase_q, phase_d;    // 0: read half, 1: write half of a read-write element
  logic                     pass_q, pass_d;
  logic [ADDRESS_WIDTH-1:0] fail_address_q, fail_address_d;
  logic [WIDTH-1:0]         fail_expected_q, fail_expected_d;
  logic [WIDTH-1:0]         fail_actual_q, fail_actual_d;

  logic             running;
  logic             is_rw;      // M1..M4 do a read then a write at every address
  logic             is_down;    // M3, M4 walk the addresses downwards
  logic             rd_op;
  logic             wr_op;
  logic             last_addr;
  logic             mismatch;
  logic [WIDTH-1:0] rd_pattern;
  logic [WIDTH-1:0] wr_pattern;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      elem_q          <= '0;
      addr_q          <= '0;
      phase_q         <= 1'b0;
      pass_q          <= 1'b0;
      fail_address_q  <= '0;
      fail_expected_q <= '0;
      fail_actual_q   <= '0;
    end else begin
      state_q         <= state_d;
      elem_q          <= elem_d;
      addr_q          <= addr_d;
      phase_q         <= phase_d;
      pass_q          <= pass_d;
      fail_address_q  <= fail_address_d;
      fail_expected_q <= fail_expected_d;
      fail_actual_q   <= fail_actual_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    elem_d          = elem_q;
    addr_d          = addr_q;
    phase_d         = phase_q;
    pass_d          = pass_q;
    fail_address_d  = fail_address_q;
    fail_expected_d = fail_expected_q;
    fail_actual_d   = fail_actual_q;

    // Operation decode for the current (element, phase). M0 is write-only, M5 is read-only.
    running    = (state_q == S_RUN);
    is_rw      = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    is_down    = (elem_q == 3'd3) || (elem_q == 3'd4);
    rd_op      = running && ((elem_q == ELEM_LAST) || (is_rw && !phase_q));
    wr_op      = running && ((elem_q == 3'd0) || (is_rw && phase_q));
    rd_pattern = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~BACKGROUND : BACKGROUND;
    wr_pattern = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~BACKGROUND : BACKGROUND;
    last_addr  = is_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    mismatch   = rd_op && (ram.read_data != rd_pattern);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_d         = S_RUN;
          elem_d          = '0;
          addr_d          = '0;
          phase_d         = 1'b0;
          pass_d          = 1'b1;
          fail_address_d  = '0;
          fail_expected_d = '0;
          fail_actual_d   = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          // pass_q still set means no earlier mismatch in this run, so this one is the first.
          if (mismatch) begin
            pass_d = 1'b0;
            if (pass_q) begin
              fail_address_d  = addr_q;
              fail_expected_d = rd_pattern;
              fail_actual_d   = ram.read_data;
            end
          end
          if (mismatch && STOP_ON_FAIL) begin
            state_d = S_DONE;
          end else if (is_rw && !phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (!last_addr) begin
              addr_d = is_down ? addr_q - 1'b1 : addr_q + 1'b1;
            end else if (elem_q == ELEM_LAST) begin
              state_d = S_DONE;
            end else begin
              elem_d = elem_q + 3'd1;
              // M2 -> M3 and M3 -> M4 start at the top address; every other element starts at 0.
              addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy              = running;
    done              = (state_q == S_DONE);
    pass              = pass_q;
    fail_address      = fail_address_q;
    fail_expected     = fail_expected_q;
    fail_actual       = fail_actual_q;
    ram.read_enable   = rd_op;
    ram.write_enable  = wr_op;
    ram.address       = running ? addr_q : '0;
    ram.write_data    = wr_op ? wr_pattern : '0;
  end

endmodule

// File: tb/tb_ram_march_tester.sv
// Self-checking bench for ram_march_tester: three instances (DEPTH 16 run-to-end, DEPTH 16 stop-on-fail,
// DEPTH 12 with a non-zero background), each with a behavioural RAM that can hold one stuck-at bit.
// Directed table, randomized runs against a reference op list, plus abort / reset / start corner cases.
module tb_ram_march_tester;
  localparam int W  = 8;
  localparam int AW = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } op_t;

  typedef struct {
    int            dut;
    bit            fen;
    logic [AW-1:0] faddr;
    logic [2:0]    fbit;
    logic          fval;
    int            mid;
    int            busy;
    bit            pass;
    logic [AW-1:0] efa;
    logic [W-1:0]  efe;
    logic [W-1:0]  efact;
  } vec_t;

  logic clock;
  logic resetn;
  logic          start [3];
  logic          abort [3];
  logic          busy  [3];
  logic          done  [3];
  logic          pass  [3];
  logic [AW-1:0] fa    [3];
  logic [W-1:0]  fe    [3];
  logic [W-1:0]  fact  [3];
  logic          we    [3];
  logic          re    [3];
  logic [AW-1:0] ad    [3];
  logic [W-1:0]  wd    [3];
  logic [W-1:0]  rd    [3];

  logic [W-1:0]  mem   [3][16];
  logic          f_en  [3];
  logic [AW-1:0] f_addr[3];
  logic [2:0]    f_bit [3];
  logic          f_val [3];

  int checks = 0;
  int errors = 0;
  op_t exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  ram_march_tester_if #(.WIDTH(W), .ADDRESS_WIDTH(AW)) bus0 ();
  ram_march_tester_if #(.WIDTH(W), .ADDRESS_WIDTH(AW)) bus1 ();
  ram_march_tester_if #(.WIDTH(W), .ADDRESS_WIDTH(AW)) bus2 ();

  ram_march_tester #(.WIDTH(W), .DEPTH(16), .BACKGROUND(8'h00), .STOP_ON_FAIL(1'b0)) u0 (
    .clock(clock), .resetn(resetn), .start(start[0]), .abort(abort[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .fail_address(fa[0]), .fail_expected(fe[0]),
    .fail_actual(fact[0]), .ram(bus0.master));
  ram_march_tester #(.WIDTH(W), .DEPTH(16), .BACKGROUND(8'h00), .STOP_ON_FAIL(1'b1)) u1 (
    .clock(clock), .resetn(resetn), .start(start[1]), .abort(abort[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .fail_address(fa[1]), .fail_expected(fe[1]),
    .fail_actual(fact[1]), .ram(bus1.master));
  ram_march_tester #(.WIDTH(W), .DEPTH(12), .BACKGROUND(8'hA5), .STOP_ON_FAIL(1'b0)) u2 (
    .clock(clock), .resetn(resetn), .start(start[2]), .abort(abort[2]), .busy(busy[2]),
    .done(done[2]), .pass(pass[2]), .fail_address(fa[2]), .fail_expected(fe[2]),
    .fail_actual(fact[2]), .ram(bus2.master));

  assign we[0] = bus0.write_enable; assign re[0] = bus0.read_enable;
  assign ad[0] = bus0.address;      assign wd[0] = bus0.write_data;
  assign we[1] = bus1.write_enable; assign re[1] = bus1.read_enable;
  assign ad[1] = bus1.address;      assign wd[1] = bus1.write_data;
  assign we[2] = bus2.write_enable; assign re[2] = bus2.read_enable;
  assign ad[2] = bus2.address;      assign wd[2] = bus2.write_data;
  assign bus0.read_data = rd[0];
  assign bus1.read_data = rd[1];
  assign bus2.read_data = rd[2];

  // Behavioural RAMs; the stuck-at bit is applied on the read path.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++)
      if (we[i]) mem[i][ad[i]] <= wd[i];
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] v;
      v = mem[i][ad[i]];
      if (f_en[i] && ad[i] == f_addr[i]) v[f_bit[i]] = f_val[i];
      rd[i] = re[i] ? v : '0;
    end
  end

  function automatic int depth_of(input int d);
    return (d == 2) ? 12 : 16;
  endfunction

  function automatic logic [W-1:0] bg_of(input int d);
    return (d == 2) ? 8'hA5 : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: builds the March C- op list from the element definitions and replays it
  // against an ideal memory with the same stuck-at bit, returning the expected outcome.
  task automatic model(input int d, output int n_ops, output bit e_pass, output logic [AW-1:0] e_fa,
                       output logic [W-1:0] e_fe, output logic [W-1:0] e_fact);
    int depth;
    logic [W-1:0] b;
    logic [W-1:0] mm [16];
    depth = depth_of(d);
    b = bg_of(d);
    exp_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < depth; k++) begin
        op_t op;
        op.a = AW'((e == 3 || e == 4) ? depth - 1 - k : k);
        if (e != 0) begin
          op.we = 1'b0; op.d = (e == 2 || e == 4) ? ~b : b; exp_q.push_back(op);
        end
        if (e != 5) begin
          op.we = 1'b1; op.d = (e == 1 || e == 3) ? ~b : b; exp_q.push_back(op);
        end
      end
    end
    for (int i = 0; i < 16; i++) mm[i] = '0;
    e_pass = 1'b1; e_fa = '0; e_fe = '0; e_fact = '0;
    n_ops = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].we) mm[exp_q[i].a] = exp_q[i].d;
      else begin
        logic [W-1:0] v;
        v = mm[exp_q[i].a];
        if (f_en[d] && exp_q[i].a == f_addr[d]) v[f_bit[d]] = f_val[d];
        if (v != exp_q[i].d && e_pass) begin
          e_pass = 1'b0; e_fa = exp_q[i].a; e_fe = exp_q[i].d; e_fact = v;
          if (d == 1) begin n_ops = i + 1; break; end
        end
      end
    end
  endtask

  task automatic pulse_start(input int d);
    @(negedge clock); start[d] = 1'b1;
    @(negedge clock); start[d] = 1'b0;
  endtask

  // Runs one test on instance d, checking every cycle's RAM op against exp_q and the final status.
  task automatic run_one(input int d, input int mid, input int e_busy, input bit e_pass,
                         input logic [AW-1:0] e_fa, input logic [W-1:0] e_fe,
                         input logic [W-1:0] e_fact, input string tag);
    int cyc;
    int bad;
    pulse_start(d);
    chk({tag, ".start_clears"}, {62'd0, done[d], pass[d]}, 64'd1);
    cyc = 0; bad = 0;
    while (busy[d] && cyc < 400) begin
      if (cyc >= exp_q.size()) bad++;
      else if (we[d] !== exp_q[cyc].we || re[d] !== !exp_q[cyc].we || ad[d] !== exp_q[cyc].a ||
               (exp_q[cyc].we && wd[d] !== exp_q[cyc].d)) bad++;
      start[d] = (cyc == mid);
      cyc++;
      @(negedge clock);
    end
    start[d] = 1'b0;
    chk({tag, ".busy_cycles"}, 64'(cyc), 64'(e_busy));
    chk({tag, ".bad_ops"}, 64'(bad), 64'd0);
    chk({tag, ".done"}, {63'd0, done[d]}, 64'd1);
    chk({tag, ".pass"}, {63'd0, pass[d]}, {63'd0, e_pass});
    chk({tag, ".fail_fields"}, {40'd0, fa[d], fe[d], fact[d]}, {40'd0, e_fa, e_fe, e_fact});
    chk({tag, ".bus_idle"}, {50'd0, we[d], re[d], ad[d], wd[d]}, 64'd0);
  endtask

  vec_t vt[7];

  initial begin
    int n_ops;
    bit e_pass;
    logic [AW-1:0] e_fa;
    logic [W-1:0] e_fe, e_fact;
    int cyc;

    vt[0] = '{0, 0, 4'd0,  3'd0, 1'b0, -1,  160, 1, 4'd0,  8'h00, 8'h00};
    vt[1] = '{0, 1, 4'd5,  3'd3, 1'b1, 70,  160, 0, 4'd5,  8'h00, 8'h08};
    vt[2] = '{1, 1, 4'd5,  3'd3, 1'b1, -1,  27,  0, 4'd5,  8'h00, 8'h08};
    vt[3] = '{2, 0, 4'd0,  3'd0, 1'b0, 30,  120, 1, 4'd0,  8'h00, 8'h00};
    vt[4] = '{2, 1, 4'd11, 3'd0, 1'b0, -1,  120, 0, 4'd11, 8'hA5, 8'hA4};
    vt[5] = '{1, 1, 4'd0,  3'd7, 1'b1, 5,   17,  0, 4'd0,  8'h00, 8'h80};
    vt[6] = '{0, 1, 4'd3,  3'd2, 1'b0, -1,  160, 0, 4'd3,  8'hFF, 8'hFB};

    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; f_en[i] = 1'b0;
      f_addr[i] = '0; f_bit[i] = '0; f_val[i] = 1'b0;
    end
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outputs%0d", i),
          {27'd0, busy[i], done[i], pass[i], fa[i], fe[i], fact[i], we[i], re[i], ad[i], wd[i]}, 64'd0);
    resetn = 1'b1;

    // Directed table.
    for (int v = 0; v < 7; v++) begin
      int d;
      d = vt[v].dut;
      f_en[d] = vt[v].fen; f_addr[d] = vt[v].faddr; f_bit[d] = vt[v].fbit; f_val[d] = vt[v].fval;
      model(d, n_ops, e_pass, e_fa, e_fe, e_fact);
      run_one(d, vt[v].mid, vt[v].busy, vt[v].pass, vt[v].efa, vt[v].efe, vt[v].efact,
              $sformatf("vec%0d", v));
      f_en[d] = 1'b0;
    end

    // Randomized runs against the reference model.
    for (int r = 0; r < 12; r++) begin
      int d;
      d = $urandom_range(0, 2);
      f_en[d]   = 1'($urandom_range(0, 1));
      f_addr[d] = AW'($urandom_range(0, depth_of(d) - 1));
      f_bit[d]  = 3'($urandom_range(0, 7));
      f_val[d]  = 1'($urandom_range(0, 1));
      model(d, n_ops, e_pass, e_fa, e_fe, e_fact);
      run_one(d, $urandom_range(0, 100), n_ops, e_pass, e_fa, e_fe, e_fact, $sformatf("rnd%0d", r));
      f_en[d] = 1'b0;
    end

    // Abort during M2 (M2 begins at cycle 48 for DEPTH 16).
    pulse_start(0);
    cyc = 0;
    while (busy[0] && cyc < 50) begin cyc++; @(negedge clock); end
    chk("abort.reached_m2", 64'(cyc), 64'd50);
    abort[0] = 1'b1;
    @(negedge clock);
    abort[0] = 1'b0;
    chk("abort.status", {61'd0, busy[0], done[0], pass[0]}, 64'd0);
    chk("abort.bus_idle", {50'd0, we[0], re[0], ad[0], wd[0]}, 64'd0);

    // Abort wins over a simultaneous start.
    @(negedge clock); start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clock); start[0] = 1'b0; abort[0] = 1'b0;
    chk("abort_beats_start.busy", {63'd0, busy[0]}, 64'd0);

    // Asynchronous reset during M3 (M3 spans cycles 80..111 for DEPTH 16).
    pulse_start(0);
    cyc = 0;
    while (busy[0] && cyc < 85) begin cyc++; @(negedge clock); end
    chk("reset_mid.reached_m3", 64'(cyc), 64'd85);
    #2 resetn = 1'b0;
    #1;
    chk("reset_mid.outputs",
        {27'd0, busy[0], done[0], pass[0], fa[0], fe[0], fact[0], we[0], re[0], ad[0], wd[0]}, 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    model(0, n_ops, e_pass, e_fa, e_fe, e_fact);
    run_one(0, -1, 160, 1'b1, 4'd0, 8'h00, 8'h00, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
